// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Control word field positions (shared with the TX engine).
  localparam int CTRL_DBITS_LSB = 0;
  localparam int CTRL_POE       = 2;
  localparam int CTRL_NPB       = 3;
  localparam int CTRL_STOP2     = 4;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;

  localparam int FRAME_W = 11;

  typedef struct packed {
    logic       brk;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  // Number of data bits encoded in the low two control bits.
  function automatic logic [3:0] data_bits(input logic [1:0] dbits);
    return 4'd5 + {2'b00, dbits};
  endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Valid/ready bus carrying received frames and their error flags.
interface uart_rx_buffered_if;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_pe;
  logic       m_fe;
  logic       m_brk;

  modport master (output m_valid, m_data, m_pe, m_fe, m_brk, input m_ready);
  modport slave  (input m_valid, m_data, m_pe, m_fe, m_brk, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Generic synchronous show-ahead FIFO; head word is read straight from storage.
module uart_rx_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign dout    = mem[rptr];
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Buffered UART receiver: 16x oversampling, 3-sample majority vote, frame FIFO.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   rx,
  input  logic [DIV_W-1:0]       baud_div,
  input  logic [4:0]             ctrl,
  uart_rx_buffered_if.master     m,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overrun,
  input  logic                   clr_ovr,
  output logic                   busy
);
  localparam logic [3:0] CNT_A   = 4'(SAMPLE_MID - 1);
  localparam logic [3:0] CNT_B   = 4'(SAMPLE_MID);
  localparam logic [3:0] CNT_RES = 4'(SAMPLE_MID + 1);
  localparam logic [3:0] CNT_END = 4'(OVERSAMPLE - 1);

  rx_state_e        state;
  logic             rx_meta, rx_s, rx_prev;
  logic             fall, start_det;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       scnt;
  logic             s_a, s_b, maj;
  logic [3:0]       fmt;
  logic [7:0]       data;
  logic [2:0]       bit_idx;
  logic             pe_r, par_r;
  logic             last_bit, exp_par;
  logic             push, pop, full, empty;
  rx_entry_t        push_entry, head;
  logic             unused_stop2;

  // Second stop bit is only generated by the TX side; the receiver ignores it.
  assign unused_stop2 = ctrl[CTRL_STOP2];

  // Two-flop synchronizer plus previous-sample register for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall      = rx_prev & ~rx_s;
  assign start_det = (state == ST_IDLE) & en & fall;

  // Divisor of 0 or 1 ticks every clock; >= guards a divisor shrunk mid-count.
  assign tick = (baud_div <= DIV_W'(1)) | (div_cnt >= baud_div - DIV_W'(1));

  // Baud divider, re-phased on the start edge so samples land mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    div_cnt <= '0;
    else if (start_det || tick) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  assign maj      = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
  assign last_bit = ({1'b0, bit_idx} == data_bits(fmt[CTRL_DBITS_LSB +: 2]) - 4'd1);
  // Unused upper data bits are cleared at frame start, so a full-width XOR is exact.
  assign exp_par  = fmt[CTRL_POE] ? ^data : ~^data;

  // Receive FSM: start qualification, data shift, parity and stop checks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      scnt    <= '0;
      s_a     <= 1'b1;
      s_b     <= 1'b1;
      fmt     <= '0;
      data    <= '0;
      bit_idx <= '0;
      pe_r    <= 1'b0;
      par_r   <= 1'b0;
    end else if (!en) begin
      state <= ST_IDLE;
    end else if (state == ST_IDLE) begin
      if (fall) begin
        fmt     <= ctrl[3:0];
        scnt    <= '0;
        data    <= '0;
        bit_idx <= '0;
        pe_r    <= 1'b0;
        par_r   <= 1'b0;
        state   <= ST_START;
      end
    end else if (tick) begin
      scnt <= scnt + 1'b1;
      if (scnt == CNT_A) s_a <= rx_s;
      if (scnt == CNT_B) s_b <= rx_s;
      case (state)
        ST_START: begin
          if (scnt == CNT_RES && maj) state <= ST_IDLE;
          else if (scnt == CNT_END)   state <= ST_DATA;
        end
        ST_DATA: begin
          if (scnt == CNT_RES) data[bit_idx] <= maj;
          if (scnt == CNT_END) begin
            if (last_bit) state <= fmt[CTRL_NPB] ? ST_STOP : ST_PARITY;
            else          bit_idx <= bit_idx + 1'b1;
          end
        end
        ST_PARITY: begin
          if (scnt == CNT_RES) begin
            par_r <= maj;
            pe_r  <= maj ^ exp_par;
          end
          if (scnt == CNT_END) state <= ST_STOP;
        end
        ST_STOP: begin
          // Leave at mid-stop so the next start edge is seen promptly.
          if (scnt == CNT_RES) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  // Frame completes at the stop-bit vote; the entry is written that same cycle.
  assign push            = en & (state == ST_STOP) & tick & (scnt == CNT_RES);
  assign push_entry.data = data;
  assign push_entry.pe   = pe_r;
  assign push_entry.fe   = ~maj;
  assign push_entry.brk  = ~maj & (data == 8'h00) & (fmt[CTRL_NPB] | ~par_r);

  assign pop = m.m_valid & m.m_ready;

  uart_rx_fifo #(.W(FRAME_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign m.m_valid = ~empty;
  assign m.m_data  = head.data;
  assign m.m_pe    = head.pe;
  assign m.m_fe    = head.fe;
  assign m.m_brk   = head.brk;

  // Sticky overrun; a new overflow wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      overrun <= 1'b0;
    else if (push && full && !pop) overrun <= 1'b1;
    else if (clr_ovr)              overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: vector table, random frames, corner sequences.
module tb_uart_rx_buffered;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        rx = 1'b1;
  logic        clr_ovr = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic [4:0]  ctrl = 5'b01011;
  logic [2:0]  fifo_level;
  logic        overrun, busy;

  uart_rx_buffered_if bus();

  uart_rx_buffered #(.DEPTH(4), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rx         (rx),
    .baud_div   (baud_div),
    .ctrl       (ctrl),
    .m          (bus),
    .fifo_level (fifo_level),
    .overrun    (overrun),
    .clr_ovr    (clr_ovr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  rx_entry_t got[$];
  rx_entry_t mon_e;

  // Capture every word the consumer accepts.
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      mon_e.data = bus.m_data;
      mon_e.pe   = bus.m_pe;
      mon_e.fe   = bus.m_fe;
      mon_e.brk  = bus.m_brk;
      got.push_back(mon_e);
    end
  end

  typedef struct {
    logic [4:0] c;
    logic [7:0] d;
    logic       p;
    logic       s;
    int         gbit;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
    logic       ebrk;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Expected result derived directly from the frame rules.
  function automatic rx_entry_t model(input logic [4:0] c, input logic [7:0] d,
                                      input logic p, input logic s);
    rx_entry_t e;
    int nb;
    int ones;
    logic has_par, exp_p;
    nb      = 5 + int'(c[1:0]);
    e.data  = d & 8'((1 << nb) - 1);
    ones    = $countones(e.data);
    has_par = !c[3];
    exp_p   = c[2] ? logic'(ones % 2) : logic'(1 - ones % 2);
    e.pe    = has_par && (p != exp_p);
    e.fe    = !s;
    e.brk   = e.fe && (e.data == 8'h00) && (!has_par || !p);
    return e;
  endfunction

  // Drive one frame on rx. cut >= 0 stops after that many line bits.
  // gbit >= 0 inverts data bit gbit for 4 clk near mid-bit (one baud tick at div 4).
  task automatic send_frame(input logic [4:0] c, input logic [7:0] d, input logic p,
                            input logic s, input int gbit, input bit scramble, input int cut);
    logic [11:0] fr;
    int n, nb, bl;
    nb = 5 + int'(c[1:0]);
    bl = 16 * ((baud_div < 16'd2) ? 1 : int'(baud_div));
    fr = '0;
    n = 1;
    for (int i = 0; i < nb; i++) begin
      fr[n] = d[i];
      n = n + 1;
    end
    if (!c[3]) begin
      fr[n] = p;
      n = n + 1;
    end
    fr[n] = s;
    n = n + 1;
    if (cut >= 0 && cut < n) n = cut;
    ctrl = c;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < bl; k++) begin
        rx = fr[b] ^ ((gbit >= 0) && (b == gbit + 1) && (k >= 34) && (k < 38));
        tick_clk();
      end
      if (b == 0 && scramble) ctrl = 5'($urandom);
    end
    if (cut < 0) begin
      rx = 1'b1;
      repeat (20) tick_clk();
    end
  endtask

  task automatic expect_one(input string tag, input rx_entry_t e);
    rx_entry_t g;
    chk({tag, "_count"}, got.size(), 1);
    if (got.size() > 0) begin
      g = got.pop_front();
      chk({tag, "_data"}, g.data, e.data);
      chk({tag, "_pe"},   g.pe,   e.pe);
      chk({tag, "_fe"},   g.fe,   e.fe);
      chk({tag, "_brk"},  g.brk,  e.brk);
    end
    got.delete();
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_level"}, fifo_level, 0);
  endtask

  initial begin
    rx_entry_t e;
    rx_entry_t g;
    vecs[0]  = '{5'b01011, 8'hA5, 1'b0, 1'b1, -1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'b00110, 8'h55, 1'b1, 1'b1, -1, 8'h55, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{5'b00110, 8'h55, 1'b0, 1'b1, -1, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'b01000, 8'h1F, 1'b0, 1'b1, -1, 8'h1F, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'b01000, 8'hFF, 1'b0, 1'b1, -1, 8'h1F, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'b01011, 8'h3C, 1'b0, 1'b0, -1, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{5'b01011, 8'h00, 1'b0, 1'b0, -1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{5'b00011, 8'h01, 1'b0, 1'b1, -1, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'b00011, 8'h01, 1'b1, 1'b1, -1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{5'b00101, 8'h2A, 1'b1, 1'b1, -1, 8'h2A, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{5'b00111, 8'h00, 1'b0, 1'b0, -1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{5'b00111, 8'h00, 1'b1, 1'b0, -1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{5'b01011, 8'hA5, 1'b0, 1'b1,  3, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{5'b11011, 8'h5A, 1'b0, 1'b1, -1, 8'h5A, 1'b0, 1'b0, 1'b0};

    bus.m_ready = 1'b1;
    repeat (3) tick_clk();
    @(negedge clk);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_flags", {bus.m_pe, bus.m_fe, bus.m_brk}, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    tick_clk();
    rst = 1'b0;
    repeat (4) tick_clk();

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      send_frame(vecs[i].c, vecs[i].d, vecs[i].p, vecs[i].s, vecs[i].gbit, 1'b0, -1);
      e.data = vecs[i].ed;
      e.pe   = vecs[i].epe;
      e.fe   = vecs[i].efe;
      e.brk  = vecs[i].ebrk;
      expect_one($sformatf("vec%0d", i), e);
    end

    // False start: 16 clk low is far shorter than half a bit.
    rx = 1'b0;
    repeat (16) tick_clk();
    @(negedge clk);
    chk("false_busy_hi", busy, 1);
    rx = 1'b1;
    repeat (200) tick_clk();
    chk("false_count", got.size(), 0);
    chk("false_level", fifo_level, 0);
    chk("false_busy_lo", busy, 0);

    // Overrun with a stalled consumer.
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(5'b01011, 8'(i), 1'b0, 1'b1, -1, 1'b0, -1);
    @(negedge clk);
    chk("ovr_level", fifo_level, 4);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", bus.m_valid, 1);
    chk("ovr_head", bus.m_data, 8'h01);
    tick_clk();
    bus.m_ready = 1'b1;
    repeat (8) tick_clk();
    chk("ovr_drain_count", got.size(), 4);
    for (int i = 1; i <= 4; i++) begin
      if (got.size() > 0) begin
        g = got.pop_front();
        chk($sformatf("ovr_drain%0d", i), g.data, 8'(i));
      end
    end
    got.delete();
    chk("ovr_drain_level", fifo_level, 0);
    chk("ovr_sticky", overrun, 1);
    clr_ovr = 1'b1;
    tick_clk();
    clr_ovr = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", overrun, 0);
    tick_clk();

    // Enable dropped mid-DATA.
    send_frame(5'b01011, 8'h00, 1'b0, 1'b1, -1, 1'b0, 4);
    @(negedge clk);
    chk("en_busy_before", busy, 1);
    tick_clk();
    en = 1'b0;
    tick_clk();
    @(negedge clk);
    chk("en_busy_after", busy, 0);
    rx = 1'b1;
    repeat (150) tick_clk();
    en = 1'b1;
    repeat (4) tick_clk();
    chk("en_nopush", got.size() + int'(fifo_level), 0);
    send_frame(5'b01011, 8'h81, 1'b0, 1'b1, -1, 1'b0, -1);
    expect_one("en_next", model(5'b01011, 8'h81, 1'b0, 1'b1));

    // Reset mid-DATA also empties a pending FIFO word.
    bus.m_ready = 1'b0;
    send_frame(5'b01011, 8'h42, 1'b0, 1'b1, -1, 1'b0, -1);
    send_frame(5'b01011, 8'h00, 1'b0, 1'b1, -1, 1'b0, 4);
    @(negedge clk);
    chk("rst_mid_level_before", fifo_level, 1);
    chk("rst_mid_busy_before", busy, 1);
    tick_clk();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_level", fifo_level, 0);
    chk("rst_mid_valid", bus.m_valid, 0);
    tick_clk();
    rst = 1'b0;
    rx = 1'b1;
    bus.m_ready = 1'b1;
    repeat (150) tick_clk();
    chk("rst_mid_nopush", got.size(), 0);
    send_frame(5'b01011, 8'h81, 1'b0, 1'b1, -1, 1'b0, -1);
    expect_one("rst_next", model(5'b01011, 8'h81, 1'b0, 1'b1));

    // Random frames, random divisor, ctrl scrambled after the start bit.
    for (int i = 0; i < 24; i++) begin
      logic [4:0] c;
      logic [7:0] d;
      logic p, s;
      baud_div = 16'($urandom_range(0, 5));
      c = 5'($urandom);
      d = 8'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(c, d, p, s, -1, 1'b1, -1);
      expect_one($sformatf("rand%0d", i), model(c, d, p, s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
